// File: rtl/fcmp_writeback_pkg.sv
// Shared FPU definitions for the compare-result writeback stage:
// op encodings, canonical quiet NaNs, NaN-box constant and the buffer entry layout.
package fcmp_writeback_pkg;

  typedef enum logic [2:0] {
    OP_EQ  = 3'b000,
    OP_LT  = 3'b001,
    OP_LE  = 3'b010,
    OP_MIN = 3'b100,
    OP_MAX = 3'b101
  } fcmp_op_e;

  localparam logic [31:0] QNAN_SP   = 32'h7FC0_0000;
  localparam logic [63:0] QNAN_DP   = 64'h7FF8_0000_0000_0000;
  localparam logic [31:0] NANBOX_HI = 32'hFFFF_FFFF;

  // One buffered result; is_fp caches the destination class decoded at accept time.
  typedef struct packed {
    logic [2:0]  op;
    logic        is_fp;
    logic        sp_dp;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        invalid;
  } wb_entry_t;

  localparam int unsigned ENTRY_W = $bits(wb_entry_t);

  // True for the five op codes the compare unit defines.
  function automatic logic op_is_defined(input logic [2:0] op);
    logic r;
    case (op)
      OP_EQ, OP_LT, OP_LE, OP_MIN, OP_MAX: r = 1'b1;
      default:                             r = 1'b0;
    endcase
    return r;
  endfunction

  // True for the flag-producing ops that target the integer register file.
  function automatic logic op_is_int(input logic [2:0] op);
    logic r;
    case (op)
      OP_EQ, OP_LT, OP_LE: r = 1'b1;
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

  // True for the value-producing ops that target the FP register file.
  function automatic logic op_is_fp(input logic [2:0] op);
    logic r;
    case (op)
      OP_MIN, OP_MAX: r = 1'b1;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fcmp_wb_fifo.sv
// Result buffer: DEPTH-entry circular FIFO with wrap-around pointers and an
// occupancy counter one bit wider than the pointers so full and empty differ.
module fcmp_wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 75
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign rdata_o = mem_q[rd_ptr_q];

  // Never overfill or underflow, whatever the caller asks for.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next pointer and occupancy values; push+pop together keeps the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fcmp_writeback.sv
// Writeback stage for FP compare / min / max: buffers compare-unit results,
// formats them for the integer or FP register file and tracks the sticky
// invalid-operation flag. Undefined op codes are swallowed and reported.
module fcmp_writeback
  import fcmp_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [63:0] IN_RESULT,
  input  logic        IN_INVALID,
  input  logic [2:0]  IN_OP,
  input  logic        IN_SP_DP,
  input  logic [4:0]  IN_RD,
  output logic        INT_WE,
  output logic        FP_WE,
  output logic [4:0]  WB_RD,
  output logic [63:0] WB_DATA,
  input  logic        WB_READY,
  output logic        FFLAG_NV,
  input  logic        FFLAG_CLR,
  output logic        ILLEGAL_OP
);

  wb_entry_t            in_entry;
  wb_entry_t            head;
  logic [ENTRY_W-1:0]   head_bits;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 accept;
  logic                 push;
  logic                 retire;
  logic                 nv_set;
  logic                 fflag_nv_q, fflag_nv_d;
  logic                 illegal_q, illegal_d;

  // IN_READY depends only on registered occupancy, never on WB_READY.
  assign IN_READY = ~fifo_full;
  assign accept   = IN_VALID & IN_READY;
  assign push     = accept & op_is_defined(IN_OP);

  // Pack the incoming result into a buffer entry.
  always_comb begin
    in_entry         = '0;
    in_entry.op      = IN_OP;
    in_entry.is_fp   = op_is_fp(IN_OP);
    in_entry.sp_dp   = IN_SP_DP;
    in_entry.rd      = IN_RD;
    in_entry.result  = IN_RESULT;
    in_entry.invalid = IN_INVALID;
  end

  fcmp_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push),
    .pop_i   (retire),
    .wdata_i (in_entry),
    .rdata_o (head_bits),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head = wb_entry_t'(head_bits);

  // Drive the register-file write port from the head entry; all zero when empty.
  always_comb begin
    INT_WE  = 1'b0;
    FP_WE   = 1'b0;
    WB_RD   = 5'd0;
    WB_DATA = 64'd0;
    if (!fifo_empty) begin
      WB_RD = head.rd;
      if (head.is_fp) begin
        FP_WE = 1'b1;
        if (head.sp_dp) begin
          WB_DATA = head.result;
        end else begin
          WB_DATA = {NANBOX_HI, head.result[31:0]};
        end
      end else begin
        INT_WE  = op_is_int(head.op);
        WB_DATA = {63'd0, head.result[0]};
      end
    end else begin
      WB_RD = 5'd0;
    end
  end

  assign retire = (INT_WE | FP_WE) & WB_READY;
  assign nv_set = retire & head.invalid;

  // Sticky flag and illegal-op pulse next state; a set beats a same-cycle clear.
  always_comb begin
    fflag_nv_d = fflag_nv_q;
    illegal_d  = 1'b0;
    if (nv_set) begin
      fflag_nv_d = 1'b1;
    end else if (FFLAG_CLR) begin
      fflag_nv_d = 1'b0;
    end else begin
      fflag_nv_d = fflag_nv_q;
    end
    if (accept && !op_is_defined(IN_OP)) begin
      illegal_d = 1'b1;
    end else begin
      illegal_d = 1'b0;
    end
  end

  // Flag and pulse registers, cleared by synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fflag_nv_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      fflag_nv_q <= fflag_nv_d;
      illegal_q  <= illegal_d;
    end
  end

  assign FFLAG_NV   = fflag_nv_q;
  assign ILLEGAL_OP = illegal_q;

endmodule

// File: tb/tb_fcmp_writeback.sv
// Directed bench for fcmp_writeback (DEPTH=2): a vector table for single
// accept/retire formatting plus hand-written multi-cycle sequences.
module tb_fcmp_writeback;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [63:0] IN_RESULT;
  logic        IN_INVALID;
  logic [2:0]  IN_OP;
  logic        IN_SP_DP;
  logic [4:0]  IN_RD;
  logic        INT_WE;
  logic        FP_WE;
  logic [4:0]  WB_RD;
  logic [63:0] WB_DATA;
  logic        WB_READY;
  logic        FFLAG_NV;
  logic        FFLAG_CLR;
  logic        ILLEGAL_OP;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  fcmp_writeback #(.DEPTH(2)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_RESULT  (IN_RESULT),
    .IN_INVALID (IN_INVALID),
    .IN_OP      (IN_OP),
    .IN_SP_DP   (IN_SP_DP),
    .IN_RD      (IN_RD),
    .INT_WE     (INT_WE),
    .FP_WE      (FP_WE),
    .WB_RD      (WB_RD),
    .WB_DATA    (WB_DATA),
    .WB_READY   (WB_READY),
    .FFLAG_NV   (FFLAG_NV),
    .FFLAG_CLR  (FFLAG_CLR),
    .ILLEGAL_OP (ILLEGAL_OP)
  );

  typedef struct {
    logic [2:0]  op;
    logic        sp_dp;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        exp_int;
    logic        exp_fp;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic sp,
                       input logic [4:0] rd, input logic [63:0] res, input logic inv);
    IN_VALID   = v;
    IN_OP      = op;
    IN_SP_DP   = sp;
    IN_RD      = rd;
    IN_RESULT  = res;
    IN_INVALID = inv;
  endtask

  task automatic expect_empty(input string tag);
    chk({tag, " INT_WE"},  {63'd0, INT_WE}, 64'd0);
    chk({tag, " FP_WE"},   {63'd0, FP_WE},  64'd0);
    chk({tag, " WB_RD"},   {59'd0, WB_RD},  64'd0);
    chk({tag, " WB_DATA"}, WB_DATA,         64'd0);
  endtask

  task automatic expect_head(input string tag, input logic ei, input logic ef,
                             input logic [4:0] rd, input logic [63:0] data);
    chk({tag, " INT_WE"},  {63'd0, INT_WE}, {63'd0, ei});
    chk({tag, " FP_WE"},   {63'd0, FP_WE},  {63'd0, ef});
    chk({tag, " WB_RD"},   {59'd0, WB_RD},  {59'd0, rd});
    chk({tag, " WB_DATA"}, WB_DATA,         data);
  endtask

  initial begin
    vecs[0] = '{3'b001, 1'b1, 5'd7,  64'h0000_0000_0000_0001, 1'b1, 1'b0, 64'h0000_0000_0000_0001};
    vecs[1] = '{3'b100, 1'b0, 5'd3,  64'h0000_0000_3F80_0000, 1'b0, 1'b1, 64'hFFFF_FFFF_3F80_0000};
    vecs[2] = '{3'b101, 1'b0, 5'd31, 64'hDEAD_BEEF_4049_0FDB, 1'b0, 1'b1, 64'hFFFF_FFFF_4049_0FDB};
    vecs[3] = '{3'b101, 1'b1, 5'd1,  64'h4009_21FB_5444_2D18, 1'b0, 1'b1, 64'h4009_21FB_5444_2D18};
    vecs[4] = '{3'b000, 1'b1, 5'd0,  64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 64'h0000_0000_0000_0000};
    vecs[5] = '{3'b010, 1'b0, 5'd12, 64'h8000_0000_0000_0003, 1'b1, 1'b0, 64'h0000_0000_0000_0001};
    vecs[6] = '{3'b100, 1'b1, 5'd20, 64'h7FF8_0000_0000_0000, 1'b0, 1'b1, 64'h7FF8_0000_0000_0000};

    RST       = 1'b1;
    WB_READY  = 1'b0;
    FFLAG_CLR = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 5'd0, 64'd0, 1'b0);
    tick();
    tick();
    RST = 1'b0;
    tick();

    // Reset state
    chk("rst IN_READY",   {63'd0, IN_READY},   64'd1);
    chk("rst FFLAG_NV",   {63'd0, FFLAG_NV},   64'd0);
    chk("rst ILLEGAL_OP", {63'd0, ILLEGAL_OP}, 64'd0);
    expect_empty("rst");

    // Table: accept, head visible one cycle later, retired the cycle after
    WB_READY = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].sp_dp, vecs[i].rd, vecs[i].result, 1'b0);
      tick();
      drive(1'b0, 3'b000, 1'b0, 5'd0, 64'd0, 1'b0);
      expect_head($sformatf("vec%0d", i), vecs[i].exp_int, vecs[i].exp_fp, vecs[i].rd, vecs[i].exp_data);
      chk($sformatf("vec%0d ILLEGAL_OP", i), {63'd0, ILLEGAL_OP}, 64'd0);
      tick();
      expect_empty($sformatf("vec%0d after", i));
    end
    chk("table FFLAG_NV", {63'd0, FFLAG_NV}, 64'd0);

    // Backpressure: three back-to-back offers, only two fit
    WB_READY = 1'b0;
    drive(1'b1, 3'b001, 1'b1, 5'd1, 64'h1, 1'b0);
    tick();
    chk("bp one IN_READY", {63'd0, IN_READY}, 64'd1);
    drive(1'b1, 3'b000, 1'b1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    tick();
    chk("bp two IN_READY", {63'd0, IN_READY}, 64'd0);
    expect_head("bp full head", 1'b1, 1'b0, 5'd1, 64'd1);
    drive(1'b1, 3'b010, 1'b1, 5'd3, 64'h1, 1'b0);
    tick();
    chk("bp three IN_READY", {63'd0, IN_READY}, 64'd0);
    expect_head("bp hold head", 1'b1, 1'b0, 5'd1, 64'd1);
    drive(1'b0, 3'b000, 1'b0, 5'd0, 64'd0, 1'b0);
    WB_READY = 1'b1;
    tick();
    expect_head("bp second", 1'b1, 1'b0, 5'd2, 64'd0);
    chk("bp drain IN_READY", {63'd0, IN_READY}, 64'd1);
    tick();
    expect_empty("bp drained");

    // Simultaneous accept and retire keeps occupancy and order
    WB_READY = 1'b0;
    drive(1'b1, 3'b101, 1'b1, 5'd4, 64'h1111_2222_3333_4444, 1'b0);
    tick();
    expect_head("sim A", 1'b0, 1'b1, 5'd4, 64'h1111_2222_3333_4444);
    drive(1'b1, 3'b001, 1'b1, 5'd5, 64'h1, 1'b0);
    WB_READY = 1'b1;
    tick();
    expect_head("sim B", 1'b1, 1'b0, 5'd5, 64'd1);
    chk("sim B IN_READY", {63'd0, IN_READY}, 64'd1);
    drive(1'b1, 3'b100, 1'b0, 5'd6, 64'h0000_0000_C000_0000, 1'b0);
    tick();
    expect_head("sim C", 1'b0, 1'b1, 5'd6, 64'hFFFF_FFFF_C000_0000);
    WB_READY = 1'b0;
    drive(1'b1, 3'b000, 1'b1, 5'd8, 64'h1, 1'b0);
    tick();
    chk("sim full IN_READY", {63'd0, IN_READY}, 64'd0);
    expect_head("sim C held", 1'b0, 1'b1, 5'd6, 64'hFFFF_FFFF_C000_0000);
    drive(1'b0, 3'b000, 1'b0, 5'd0, 64'd0, 1'b0);
    WB_READY = 1'b1;
    tick();
    expect_head("sim D", 1'b1, 1'b0, 5'd8, 64'd1);
    tick();
    expect_empty("sim drained");

    // Sticky invalid flag
    drive(1'b1, 3'b000, 1'b1, 5'd9, 64'h1, 1'b1);
    tick();
    drive(1'b0, 3'b000, 1'b0, 5'd0, 64'd0, 1'b0);
    chk("nv before retire", {63'd0, FFLAG_NV}, 64'd0);
    tick();
    chk("nv set", {63'd0, FFLAG_NV}, 64'd1);
    drive(1'b1, 3'b001, 1'b1, 5'd10, 64'h0, 1'b1);
    tick();
    drive(1'b0, 3'b000, 1'b0, 5'd0, 64'd0, 1'b0);
    FFLAG_CLR = 1'b1;
    tick();
    chk("nv set beats clr", {63'd0, FFLAG_NV}, 64'd1);
    tick();
    chk("nv lone clr", {63'd0, FFLAG_NV}, 64'd0);
    FFLAG_CLR = 1'b0;
    drive(1'b1, 3'b000, 1'b1, 5'd11, 64'h1, 1'b0);
    tick();
    drive(1'b0, 3'b000, 1'b0, 5'd0, 64'd0, 1'b0);
    tick();
    chk("nv clean retire", {63'd0, FFLAG_NV}, 64'd0);

    // Undefined op codes: accepted, not enqueued, one-cycle pulse
    for (int k = 0; k < 3; k++) begin
      logic [2:0] bad;
      bad = (k == 0) ? 3'b110 : ((k == 1) ? 3'b011 : 3'b111);
      drive(1'b1, bad, 1'b1, 5'd13, 64'h1, 1'b0);
      tick();
      drive(1'b0, 3'b000, 1'b0, 5'd0, 64'd0, 1'b0);
      chk($sformatf("ill%0d pulse", k), {63'd0, ILLEGAL_OP}, 64'd1);
      chk($sformatf("ill%0d IN_READY", k), {63'd0, IN_READY}, 64'd1);
      expect_empty($sformatf("ill%0d", k));
      tick();
      chk($sformatf("ill%0d pulse end", k), {63'd0, ILLEGAL_OP}, 64'd0);
    end

    // Reset with two entries buffered discards them
    WB_READY = 1'b0;
    drive(1'b1, 3'b001, 1'b1, 5'd14, 64'h1, 1'b1);
    tick();
    drive(1'b1, 3'b101, 1'b1, 5'd15, 64'h5555_AAAA_5555_AAAA, 1'b1);
    tick();
    drive(1'b0, 3'b000, 1'b0, 5'd0, 64'd0, 1'b0);
    chk("mrst pre IN_READY", {63'd0, IN_READY}, 64'd0);
    chk("mrst pre INT_WE", {63'd0, INT_WE}, 64'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mrst IN_READY", {63'd0, IN_READY}, 64'd1);
    expect_empty("mrst");
    WB_READY = 1'b1;
    tick();
    expect_empty("mrst after");
    chk("mrst FFLAG_NV", {63'd0, FFLAG_NV}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
